ex_mem_latch: RTL

EX_MEM_LATCH -- requirements
Module: ex_mem_latch

---
 rtl/ex_mem_latch.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ex_mem_latch.sv
// ex_mem_latch: EX/MEM pipeline register with debug hold, flush bubbles,
// post-HALT squashing, a sticky HALT flag and a retired-instruction counter.
// Optional build macro MISALIGN_CHECK_EN adds word/half alignment checking
// with a sticky error flag and first-error address capture.
//
// Handshake: there is no valid/ready pair here. i_enable is a global
// advance qualifier (0 freezes everything); o_mem_valid marks a real
// instruction on the MEM side and is updated only on enabled edges.
module ex_mem_latch #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic             i_ex_valid,
    input  logic [31:0]      i_ex_alu_result,
    input  logic [31:0]      i_ex_write_data,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_mem_write,
    input  logic             i_ex_mem_to_reg,
    input  logic             i_ex_reg_write,
    input  logic [2:0]       i_ex_bhw_type,
    input  logic             i_ex_halt,
    output logic [31:0]      o_mem_alu_result_or_addr,
    output logic [31:0]      o_mem_write_data,
    output logic [4:0]       o_mem_rd,
    output logic             o_m_mem_read,
    output logic             o_m_mem_write,
    output logic             o_m_mem_to_reg,
    output logic             o_m_reg_write,
    output logic [2:0]       o_m_bhw_type,
    output logic             o_mem_valid,
    output logic             o_halt_seen,
    output logic [CNT_W-1:0] o_retired_count
`ifdef MISALIGN_CHECK_EN
    ,
    output logic             o_misalign_err,
    output logic [31:0]      o_misalign_addr
`endif
);

    // What the register does on the coming edge (reset handled separately).
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_LOAD   = 2'd2
    } act_e;

    act_e act;
    logic accept;
    logic misaligned;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A real instruction is only taken if no HALT has retired before it.
    assign accept = i_ex_valid && !o_halt_seen;

`ifdef MISALIGN_CHECK_EN
    logic is_word;
    logic is_half;

    // Decode the access-size code into word / half classes; bytes never misalign.
    always_comb begin
        is_word = 1'b0;
        is_half = 1'b0;
        case (i_ex_bhw_type)
            3'b001, 3'b101: is_word = 1'b1;
            3'b010, 3'b111: is_half = 1'b1;
            default: ;
        endcase
    end

    assign misaligned = accept && (i_ex_mem_read || i_ex_mem_write) &&
                        ((is_word && (i_ex_alu_result[1:0] != 2'b00)) ||
                         (is_half && i_ex_alu_result[0]));
`else
    assign misaligned = 1'b0;
`endif

    // Select hold / bubble / load by priority: hold beats flush beats load.
    always_comb begin
        act = ACT_HOLD;
        if (i_enable) begin
            if (i_flush || !accept) begin
                act = ACT_BUBBLE;
            end else begin
                act = ACT_LOAD;
            end
        end
    end

    // Pipeline register, sticky HALT flag and retired counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_mem_alu_result_or_addr <= '0;
            o_mem_write_data         <= '0;
            o_mem_rd                 <= '0;
            o_m_mem_read             <= 1'b0;
            o_m_mem_write            <= 1'b0;
            o_m_mem_to_reg           <= 1'b0;
            o_m_reg_write            <= 1'b0;
            o_m_bhw_type             <= '0;
            o_mem_valid              <= 1'b0;
            o_halt_seen              <= 1'b0;
            o_retired_count          <= '0;
        end else begin
            case (act)
                ACT_BUBBLE: begin
                    o_mem_alu_result_or_addr <= '0;
                    o_mem_write_data         <= '0;
                    o_mem_rd                 <= '0;
                    o_m_mem_read             <= 1'b0;
                    o_m_mem_write            <= 1'b0;
                    o_m_mem_to_reg           <= 1'b0;
                    o_m_reg_write            <= 1'b0;
                    o_m_bhw_type             <= '0;
                    o_mem_valid              <= 1'b0;
                end
                ACT_LOAD: begin
                    // A misaligned entry still retires but loses its side effects.
                    o_mem_alu_result_or_addr <= i_ex_alu_result;
                    o_mem_write_data         <= i_ex_write_data;
                    o_mem_rd                 <= i_ex_rd;
                    o_m_mem_read             <= i_ex_mem_read   && !misaligned;
                    o_m_mem_write            <= i_ex_mem_write  && !misaligned;
                    o_m_mem_to_reg           <= i_ex_mem_to_reg && !misaligned;
                    o_m_reg_write            <= i_ex_reg_write  && !misaligned;
                    o_m_bhw_type             <= i_ex_bhw_type;
                    o_mem_valid              <= 1'b1;
                    o_retired_count          <= o_retired_count + CNT_ONE;
                    if (i_ex_halt) begin
                        o_halt_seen <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_CHECK_EN
    // Sticky misalignment flag; the address of the first offender is kept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_misalign_err  <= 1'b0;
            o_misalign_addr <= '0;
        end else if (act == ACT_LOAD && misaligned && !o_misalign_err) begin
            o_misalign_err  <= 1'b1;
            o_misalign_addr <= i_ex_alu_result;
        end
    end
`endif

endmodule
